// File: rtl/nrzi_decoder_if.sv
// Bus between an NRZI line source and the decoder: bit strobe, line level,
// framing enable, decoded-bit stream and the valid/ready word holding register.
//   master: drives bit_en, line_in, frame_en, data_ready; observes the rest
//   slave : the decoder side (nrzi_decoder)
interface nrzi_decoder_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              line_in;
  logic              frame_en;
  logic              bit_out;
  logic              bit_out_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              stuff_err;
  logic              overrun;

  modport master (
    output bit_en, line_in, frame_en, data_ready,
    input  bit_out, bit_out_valid, data_out, data_valid, stuff_err, overrun
  );

  modport slave (
    input  bit_en, line_in, frame_en, data_ready,
    output bit_out, bit_out_valid, data_out, data_valid, stuff_err, overrun
  );
endinterface

// File: rtl/nrzi_decoder.sv
// NRZI receive decoder. A line toggle is a 1, a held level is a 0. On every
// bit_en strobe the line is compared with the previous sample, stuffed zeros
// (after STUFF_LEN consecutive ones) are removed, stuffing violations are
// flagged and data bits are assembled LSB-first into DATA_W-bit words that
// are offered through a single valid/ready holding register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - nrzi_decoder_if.slave (bit_en, line_in, frame_en, data_ready in;
//          bit_out, bit_out_valid, data_out, data_valid, stuff_err, overrun out)
module nrzi_decoder #(
  parameter int DATA_W     = 8,
  parameter int STUFF_LEN  = 6,
  parameter bit STUFF_EN   = 1'b1,
  parameter bit INIT_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           rst,
  nrzi_decoder_if.slave bus
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int BW = $clog2(DATA_W);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              r_prev_line;
  logic [OW-1:0]     r_ones_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_bit_out;
  logic              r_bit_out_valid;
  logic              r_stuff_err;
  logic              r_overrun;

  logic              w_dec;
  logic              w_at_stuff;
  logic              w_data_bit;
  logic              w_complete;
  logic [DATA_W-1:0] w_word;
  logic [OW-1:0]     w_ones_next;

  // Decode the current sample and classify it as stuff slot or data bit.
  always_comb begin
    w_dec       = bus.line_in ^ r_prev_line;
    w_at_stuff  = STUFF_EN && (r_ones_cnt == ONES_MAX);
    w_data_bit  = bus.bit_en && bus.frame_en && !w_at_stuff;
    w_complete  = w_data_bit && (r_bit_cnt == BIT_LAST);
    // Partial word with the current bit merged at its slot.
    w_word             = r_shift;
    w_word[r_bit_cnt]  = w_dec;
    // Ones counter saturates so it cannot wrap when unstuffing is disabled.
    if (!w_dec) begin
      w_ones_next = '0;
    end else if (r_ones_cnt == ONES_MAX) begin
      w_ones_next = r_ones_cnt;
    end else begin
      w_ones_next = r_ones_cnt + OW'(1);
    end
  end

  // Line tracking, unstuffing and word assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_line     <= INIT_LEVEL;
      r_ones_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_bit_out       <= 1'b0;
      r_bit_out_valid <= 1'b0;
      r_stuff_err     <= 1'b0;
    end else begin
      r_bit_out_valid <= 1'b0;
      r_stuff_err     <= 1'b0;
      // Line history is kept even while the deserializer is idle.
      if (bus.bit_en) begin
        r_prev_line <= bus.line_in;
      end
      if (!bus.frame_en) begin
        r_ones_cnt <= '0;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
      end else if (bus.bit_en) begin
        if (w_at_stuff) begin
          r_ones_cnt <= '0;
          // A one in the stuff slot breaks the framing: drop the partial word.
          if (w_dec) begin
            r_stuff_err <= 1'b1;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
          end
        end else begin
          r_ones_cnt      <= w_ones_next;
          r_bit_out       <= w_dec;
          r_bit_out_valid <= 1'b1;
          if (w_complete) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
            r_shift   <= w_word;
          end
        end
      end
    end
  end

  // Holding register: load on completion when free or being drained,
  // otherwise report the lost word; clear on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_data_valid || bus.data_ready) begin
          r_data_out   <= w_word;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_data_valid && bus.data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.bit_out       = r_bit_out;
  assign bus.bit_out_valid = r_bit_out_valid;
  assign bus.data_out      = r_data_out;
  assign bus.data_valid    = r_data_valid;
  assign bus.stuff_err     = r_stuff_err;
  assign bus.overrun       = r_overrun;

endmodule

// File: tb/tb_nrzi_decoder.sv
// Self-checking bench for nrzi_decoder (DATA_W=8, STUFF_LEN=6, unstuffing on).
// A behavioural model built from the decoding rules (bit queue, integer
// counters) is stepped alongside the DUT and compared every cycle; a vector
// table and hand-written sequences cover the directed scenarios.
module tb_nrzi_decoder;
  localparam int DW = 8;
  localparam int SL = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nrzi_decoder_if #(.DATA_W(DW)) bus ();

  nrzi_decoder #(
    .DATA_W(DW), .STUFF_LEN(SL), .STUFF_EN(1'b1), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_prev, m_ones, m_data, m_valid, m_bit;
  int e_bov, e_serr, e_ovr;
  bit q[$];

  // observed pulse counters
  int cnt_bov = 0, cnt_serr = 0, cnt_ovr = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_ones = 0; m_data = 0; m_valid = 0; m_bit = 0;
    e_bov = 0; e_serr = 0; e_ovr = 0;
    q.delete();
  endtask

  task automatic model_step(input bit be, input bit ln, input bit fe, input bit rd);
    int dec, word, completed;
    e_bov = 0; e_serr = 0; e_ovr = 0; completed = 0;
    if (be) begin
      dec = ln ^ m_prev[0];
      m_prev = ln;
      if (!fe) begin
        q.delete(); m_ones = 0;
      end else if (m_ones == SL) begin
        m_ones = 0;
        if (dec == 1) begin
          e_serr = 1;
          q.delete();
        end
      end else begin
        m_ones = dec ? m_ones + 1 : 0;
        m_bit = dec; e_bov = 1;
        q.push_back(dec[0]);
        if (q.size() == DW) begin
          word = 0;
          for (int i = 0; i < DW; i++) word += int'(q[i]) << i;
          q.delete();
          completed = 1;
          if (m_valid == 0 || rd) begin
            m_data = word; m_valid = 1;
          end else begin
            e_ovr = 1;
          end
        end
      end
    end else if (!fe) begin
      q.delete(); m_ones = 0;
    end
    if (m_valid == 1 && rd && !completed) m_valid = 0;
  endtask

  task automatic compare_all();
    cnt_bov  += int'(bus.bit_out_valid);
    cnt_serr += int'(bus.stuff_err);
    cnt_ovr  += int'(bus.overrun);
    check("bit_out_valid", int'(bus.bit_out_valid), e_bov);
    check("bit_out",       int'(bus.bit_out),       m_bit);
    check("data_valid",    int'(bus.data_valid),    m_valid);
    check("data_out",      int'(bus.data_out),      m_data);
    check("stuff_err",     int'(bus.stuff_err),     e_serr);
    check("overrun",       int'(bus.overrun),       e_ovr);
  endtask

  // one clock: drive at negedge, model, sample at following negedge
  task automatic cycle(input bit be, input bit ln, input bit fe, input bit rd);
    bus.bit_en = be; bus.line_in = ln; bus.frame_en = fe; bus.data_ready = rd;
    model_step(be, ln, fe, rd);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.bit_en = 1'b1; bus.line_in = 1'b1; bus.frame_en = 1'b1; bus.data_ready = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    bus.bit_en = 1'b0;
  endtask

  task automatic send_bit(input bit d, input bit fe, input bit rd, input int gap);
    bit ln;
    ln = m_prev[0] ^ d;
    cycle(1'b1, ln, fe, rd);
    repeat (gap) cycle(1'b0, ln, fe, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rd_last);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b1, (i == 7) ? rd_last : 1'b0, 1);
  endtask

  typedef struct {
    bit         line;
    bit         e_bov;
    bit         e_bit;
    bit         e_dv;
    logic [7:0] e_do;
  } vec_t;

  initial begin
    vec_t tbl[8];
    bit   lines[9];
    int   b0, s0, o0;
    bit   fe_r, be_r, d_r, ln_r;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};

    rst = 1'b1;
    bus.bit_en = 1'b0; bus.line_in = 1'b0; bus.frame_en = 1'b1; bus.data_ready = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Directed: 0xA5, one strobe every 4th cycle
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].line, 1'b1, 1'b0);
      check("t1_bov",  int'(bus.bit_out_valid), int'(tbl[i].e_bov));
      check("t1_bit",  int'(bus.bit_out),       int'(tbl[i].e_bit));
      check("t1_dv",   int'(bus.data_valid),    int'(tbl[i].e_dv));
      check("t1_data", int'(bus.data_out),      int'(tbl[i].e_do));
      repeat (3) cycle(1'b0, tbl[i].line, 1'b1, 1'b0);
    end
    repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_hold_dv", int'(bus.data_valid), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_accept_dv",   int'(bus.data_valid), 0);
    check("t1_accept_data", int'(bus.data_out),   32'hA5);

    // 0xFF with a stuffed zero after six ones
    do_reset();
    lines = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    b0 = cnt_bov; s0 = cnt_serr;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, lines[i], 1'b1, 1'b0);
      cycle(1'b0, lines[i], 1'b1, 1'b0);
    end
    check("t2_bov_count", cnt_bov - b0, 8);
    check("t2_serr",      cnt_serr - s0, 0);
    check("t2_data",      int'(bus.data_out), 32'hFF);
    check("t2_dv",        int'(bus.data_valid), 1);

    // Stuffing violation: seven ones
    do_reset();
    b0 = cnt_bov;
    for (int i = 0; i < 7; i++) cycle(1'b1, (i % 2 == 0), 1'b1, 1'b0);
    check("t3_serr",      int'(bus.stuff_err), 1);
    check("t3_no_bov",    int'(bus.bit_out_valid), 0);
    check("t3_bov_count", cnt_bov - b0, 6);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b0, 1);
    check("t3_dv",   int'(bus.data_valid), 1);
    check("t3_data", int'(bus.data_out), 0);

    // Overrun, then the same with data_ready at the completing strobe
    do_reset();
    send_byte(8'h3C, 1'b0);
    o0 = cnt_ovr;
    send_byte(8'hC3, 1'b0);
    check("t4_ovr_count", cnt_ovr - o0, 1);
    check("t4_data",      int'(bus.data_out), 32'h3C);
    check("t4_dv",        int'(bus.data_valid), 1);
    do_reset();
    send_byte(8'h3C, 1'b0);
    o0 = cnt_ovr;
    send_byte(8'hC3, 1'b1);
    check("t4b_ovr_count", cnt_ovr - o0, 0);
    check("t4b_data",      int'(bus.data_out), 32'hC3);
    check("t4b_dv",        int'(bus.data_valid), 1);

    // frame_en gap after 3 bits, line history kept across it
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0, 1);
    send_bit(1'b0, 1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b0, 1'b0, 1);
    send_bit(1'b1, 1'b0, 1'b0, 1);
    send_byte(8'h5A, 1'b0);
    check("t5_data", int'(bus.data_out), 32'h5A);
    check("t5_dv",   int'(bus.data_valid), 1);

    // Asynchronous reset mid-word
    do_reset();
    send_byte(8'h0F, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b1, 1'b0, 1);
    send_bit(1'b0, 1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, ~m_prev[0], 1'b1, 1'b0);
    bus.bit_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_bit_out", int'(bus.bit_out), 0);
    check("t6_bov",     int'(bus.bit_out_valid), 0);
    check("t6_dv",      int'(bus.data_valid), 0);
    check("t6_data",    int'(bus.data_out), 0);
    check("t6_serr",    int'(bus.stuff_err), 0);
    check("t6_ovr",     int'(bus.overrun), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h81, 1'b0);
    check("t6_data_81", int'(bus.data_out), 32'h81);

    // Randomized run, ones-biased to exercise stuffing
    do_reset();
    fe_r = 1'b1; ln_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      be_r = ($urandom_range(0, 1) == 1);
      if (be_r) begin
        d_r  = ($urandom_range(0, 9) < 8);
        ln_r = m_prev[0] ^ d_r;
        if ($urandom_range(0, 59) == 0) fe_r = ~fe_r;
        else if (!fe_r && $urandom_range(0, 3) == 0) fe_r = 1'b1;
      end
      cycle(be_r, ln_r, fe_r, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nrzi_decoder.md
Name: nrzi_decoder

Overview:
Receive-side counterpart of the team's NRZI encoders, which toggle the line for a 1 and hold it for a 0. The block samples the NRZI line on a bit strobe and recovers the data bits. It removes stuffed zeros, flags stuffing violations, and assembles LSB-first words. Completed words are delivered through a valid/ready holding register to downstream framing logic.

Parameters:
DATA_W, 8, width of an assembled output word (2..32)
STUFF_LEN, 6, number of consecutive decoded 1s after which the next bit is a stuffed 0
STUFF_EN, 1, 1 = bit-unstuffing active; 0 = no bits dropped, stuff_err never asserts
INIT_LEVEL, 0, line level assumed at reset; matches the encoder's reset output

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
bit_en  in  1  one-cycle bit strobe; line_in is sampled only when high
line_in  in  1  NRZI line, synchronous to clk
frame_en  in  1  0 = deserializer held idle (bit/ones counters cleared)
bit_out  out  1  last decoded data bit, stuffed bits excluded
bit_out_valid  out  1  one-cycle pulse qualifying bit_out
data_out  out  DATA_W  assembled word, first-received bit in bit 0
data_valid  out  1  data_out holds an unconsumed word
data_ready  in  1  consumer accepts data_out when data_valid && data_ready
stuff_err  out  1  one-cycle pulse: stuffing violation
overrun  out  1  one-cycle pulse: completed word lost because the holding register was full

Behaviour:
- Reset: prev_line=INIT_LEVEL; ones_cnt=0; bit_cnt=0; shift=0; data_out=0.
- Reset: bit_out=0; bit_out_valid=0; data_valid=0; stuff_err=0; overrun=0.
- Reset mid-word discards all partial state. No output changes on cycles without bit_en, except data_valid clearing on accept.
- Decode on each bit_en cycle: dec = line_in XOR prev_line. prev_line <= line_in on every bit_en, regardless of frame_en.
- frame_en=0: ones_cnt, bit_cnt and shift cleared; no bit_out_valid, stuff_err or word completion. A held word remains in data_out.
- Stuff check, STUFF_EN=1, when ones_cnt==STUFF_LEN at a bit_en:
  - dec=0: stuffed bit dropped (no bit_out_valid, no shift); ones_cnt<=0.
  - dec=1: stuff_err pulses next cycle; bit dropped; ones_cnt<=0; bit_cnt and shift cleared (partial word discarded).
- Normal data bit (any other case): ones_cnt<=dec ? ones_cnt+1 : 0; bit_out<=dec; bit_out_valid pulses.
  - Bit enters shift at position bit_cnt; bit_cnt increments.
  - With STUFF_EN=0, ones_cnt still counts but is never acted on.
- Latency: registered outputs appear the cycle after the bit_en edge.
- Word completion: the data bit making bit_cnt==DATA_W sets bit_cnt<=0.
  - If the holding register is free, or data_ready=1 that cycle: data_out<=word and data_valid=1, aligned with that bit's bit_out_valid.
  - If data_valid=1 and data_ready=0: overrun pulses; data_out and data_valid keep the old word; new word dropped.
- Accept: data_valid && data_ready with no simultaneous completion -> data_valid<=0 next cycle; data_out unchanged.
- ones_cnt wraps nowhere; width is clog2(STUFF_LEN+1). With STUFF_EN=0 it saturates at STUFF_LEN.
- bit_en is ignored while rst is high.

Test Plan:
- Reset, then DATA_W=8 with bit_en every 4th cycle and line levels 1,1,0,0,0,1,1,0 -> decoded bits 1,0,1,0,0,1,0,1; data_out=0xA5 and data_valid=1 one cycle after the 8th strobe; holds until data_ready.
- 0xFF stuffed (STUFF_LEN=6): line 1,0,1,0,1,0,0,1,0 -> 8 bit_out_valid pulses (the 7th strobe is dropped); data_out=0xFF after the 9th strobe; stuff_err never asserts.
- Violation: line 1,0,1,0,1,0,1 (seven decoded 1s) -> stuff_err one pulse after the 7th strobe; no 7th bit_out_valid; next 8 bits 0x00 give data_out=0x00.
- Overrun: two words 0x3C then 0xC3 with data_ready=0 -> data_out=0x3C, overrun pulses once at the second completion. Repeat with data_ready=1 at that cycle -> data_out=0xC3, no overrun.
- frame_en drop after 3 bits: 3 bits, frame_en=0 for 2 strobes, then 8 bits of 0x5A -> data_out=0x5A, with prev_line tracking preserved across the gap.
- Async rst asserted mid-word (after 5 bits, between clk edges) -> all outputs 0 immediately. Following full byte 0x81 with line starting from INIT_LEVEL -> data_out=0x81.
